// File: rtl/mem_fill_responder_if.sv
// Cache-fill bus between the cache controller (master) and the memory responder (slave).
// Read requests, write-through stores and the returned word share this bundle.
interface mem_fill_responder_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] data_out;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic                  data_valid;
    logic                  busy;

    modport master (
        output req, req_addr, wr_en, wr_addr, wr_data,
        input  data_out, addr_out, data_valid, busy
    );

    modport slave (
        input  req, req_addr, wr_en, wr_addr, wr_data,
        output data_out, addr_out, data_valid, busy
    );
endinterface

// File: rtl/mem_fill_responder.sv
// Memory-side responder for cache fills: one word read accepted per cycle, returned after a
// fixed LATENCY through a shift pipeline, plus single-cycle write-through stores.
module mem_fill_responder #(
    parameter int    ADDR_WIDTH = 16,
    parameter int    DATA_WIDTH = 16,
    parameter int    LATENCY    = 4,
    parameter string INIT_FILE  = ""
) (
    input logic                clk,
    input logic                rst_n,
    mem_fill_responder_if.slave bus
);
    localparam int WORDS = 1 << (ADDR_WIDTH - 1);
    localparam int CW    = $clog2(LATENCY + 1);

    typedef enum logic {IDLE, ACTIVE} state_e;

    logic [DATA_WIDTH-1:0] mem [WORDS];
    logic [ADDR_WIDTH-2:0] reqIdx, wrIdx;
    logic [ADDR_WIDTH-1:0] alignedReqAddr;
    logic [DATA_WIDTH-1:0] rdWord;
    logic                  unusedAddrBits;

    assign reqIdx         = bus.req_addr[ADDR_WIDTH-1:1];
    assign wrIdx          = bus.wr_addr[ADDR_WIDTH-1:1];
    assign alignedReqAddr = {bus.req_addr[ADDR_WIDTH-1:1], 1'b0};
    assign rdWord         = mem[reqIdx];
    assign unusedAddrBits = bus.req_addr[0] ^ bus.wr_addr[0];

    // NOTE: storage has no reset so contents survive rst_n; the non-blocking write means a
    // read sampled on the same edge still sees the pre-write word.
    always_ff @(posedge clk) begin
        if (bus.wr_en) mem[wrIdx] <= bus.wr_data;
    end

    // Valid bits for every stage; the top bit is data_valid.
    logic [LATENCY-1:0]    pipeValid;
    logic [ADDR_WIDTH-1:0] outAddr;
    logic [DATA_WIDTH-1:0] outData;
    logic                  lastInValid;
    logic [ADDR_WIDTH-1:0] lastInAddr;
    logic [DATA_WIDTH-1:0] lastInData;
    logic                  dataValid;

    assign dataValid = pipeValid[LATENCY-1];

    if (LATENCY == 1) begin : g_direct
        assign lastInValid = bus.req;
        assign lastInAddr  = alignedReqAddr;
        assign lastInData  = rdWord;
    end else begin : g_chain
        localparam int DEPTH = LATENCY - 1;
        logic [ADDR_WIDTH-1:0] chainAddr [DEPTH];
        logic [DATA_WIDTH-1:0] chainData [DEPTH];

        // Payload stages only move data; validity is tracked by the reset pipeValid bits.
        always_ff @(posedge clk) begin
            chainAddr[0] <= alignedReqAddr;
            chainData[0] <= rdWord;
            for (int i = 1; i < DEPTH; i++) begin
                chainAddr[i] <= chainAddr[i-1];
                chainData[i] <= chainData[i-1];
            end
        end

        assign lastInValid = pipeValid[LATENCY-2];
        assign lastInAddr  = chainAddr[DEPTH-1];
        assign lastInData  = chainData[DEPTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipeValid <= '0;
            outAddr   <= '0;
            outData   <= '0;
        end else begin
            pipeValid <= (pipeValid << 1) | LATENCY'(bus.req);
            if (lastInValid) begin
                outAddr <= lastInAddr;
                outData <= lastInData;
            end
        end
    end

    state_e        state;
    logic [CW-1:0] count, countNext;
    logic          busyQ;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        countNext = count;
        if (bus.req && !dataValid)      countNext = count + CW'(1);
        else if (!bus.req && dataValid) countNext = count - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            busyQ <= 1'b0;
        end else begin
            count <= countNext;
            busyQ <= (countNext != '0);
            case (state)
                IDLE:    if (bus.req) state <= ACTIVE;
                ACTIVE:  if (dataValid && count == CW'(1) && !bus.req) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_out   = outData;
    assign bus.addr_out   = outAddr;
    assign bus.data_valid = dataValid;
    assign bus.busy       = busyQ;
endmodule

// File: tb/tb_mem_fill_responder.sv
// Directed bench for mem_fill_responder: single read, burst, write/read collision,
// odd address, mid-burst reset and alternating requests at LATENCY=4.
module tb_mem_fill_responder;
    logic clk = 1'b0;
    logic rst_n;
    int   nChecks = 0;
    int   nErrors = 0;

    mem_fill_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    mem_fill_responder #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .LATENCY(4), .INIT_FILE("")
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic writeWord(input logic [15:0] addr, input logic [15:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        logic expDv;
        int   pulses;
        bus.req = 1'b0; bus.req_addr = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        rst_n = 1'b0;
        #1;
        check("reset_dv",   bus.data_valid, 0);
        check("reset_data", bus.data_out,   0);
        check("reset_addr", bus.addr_out,   0);
        check("reset_busy", bus.busy,       0);
        tick(); tick();
        rst_n = 1'b1;

        writeWord(16'h0010, 16'hBEEF);
        for (int i = 0; i < 8; i++) writeWord(16'h0020 + 16'(2 * i), 16'h1000 + 16'(i));
        writeWord(16'h0030, 16'h5A5A);
        writeWord(16'h0040, 16'h0000);
        tick();

        // 1) single read, cycle 0 request
        bus.req = 1'b1; bus.req_addr = 16'h0010;
        tick();
        bus.req = 1'b0;
        check("t1_busy_c1", bus.busy, 1);
        check("t1_dv_c1", bus.data_valid, 0);
        tick(); tick();
        check("t1_dv_c3", bus.data_valid, 0);
        tick();
        check("t1_dv_c4",   bus.data_valid, 1);
        check("t1_data_c4", bus.data_out,   16'hBEEF);
        check("t1_addr_c4", bus.addr_out,   16'h0010);
        check("t1_busy_c4", bus.busy,       1);
        tick();
        check("t1_dv_c5",   bus.data_valid, 0);
        check("t1_busy_c5", bus.busy,       0);
        check("t1_hold_c5", bus.data_out,   16'hBEEF);
        tick();

        // 2) 8-word burst
        for (int k = 0; k < 14; k++) begin
            bus.req      = (k < 8);
            bus.req_addr = 16'h0020 + 16'(2 * k);
            expDv = (k >= 4 && k <= 11);
            check($sformatf("t2_dv_c%0d", k), bus.data_valid, expDv);
            check($sformatf("t2_busy_c%0d", k), bus.busy, (k >= 1 && k <= 11));
            if (expDv) begin
                check($sformatf("t2_data_c%0d", k), bus.data_out, 16'h1000 + 16'(k - 4));
                check($sformatf("t2_addr_c%0d", k), bus.addr_out, 16'h0020 + 16'(2 * (k - 4)));
            end
            if (k == 4 || k == 8) check($sformatf("t2_count_c%0d", k), dut.count, 4);
            if (k == 9) check("t2_count_c9", dut.count, 3);
            tick();
        end
        bus.req = 1'b0;
        tick();

        // 3) write and read to the same word in the same cycle
        bus.wr_en = 1'b1; bus.wr_addr = 16'h0040; bus.wr_data = 16'h1234;
        bus.req = 1'b1; bus.req_addr = 16'h0040;
        tick();
        bus.wr_en = 1'b0;
        tick();
        bus.req = 1'b0;
        tick(); tick();
        check("t3_dv_c4",   bus.data_valid, 1);
        check("t3_old_c4",  bus.data_out,   16'h0000);
        check("t3_addr_c4", bus.addr_out,   16'h0040);
        tick();
        check("t3_dv_c5",   bus.data_valid, 1);
        check("t3_new_c5",  bus.data_out,   16'h1234);
        tick(); tick();

        // 4) odd byte address
        bus.req = 1'b1; bus.req_addr = 16'h0031;
        tick();
        bus.req = 1'b0;
        tick(); tick(); tick();
        check("t4_dv_c4",   bus.data_valid, 1);
        check("t4_addr_c4", bus.addr_out,   16'h0030);
        check("t4_data_c4", bus.data_out,   16'h5A5A);
        tick(); tick();

        // 5) reset in the middle of a burst
        bus.req = 1'b1; bus.req_addr = 16'h0020;
        tick();
        bus.req_addr = 16'h0022;
        tick();
        bus.req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_rst_dv",   bus.data_valid, 0);
        check("t5_rst_data", bus.data_out,   0);
        check("t5_rst_addr", bus.addr_out,   0);
        check("t5_rst_busy", bus.busy,       0);
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.data_valid === 1'b1) pulses++;
            check($sformatf("t5_busy_after_%0d", k), bus.busy, 0);
            tick();
        end
        check("t5_no_dv_pulses", pulses, 0);
        bus.req = 1'b1; bus.req_addr = 16'h0020;
        tick();
        bus.req = 1'b0;
        tick(); tick(); tick();
        check("t5_reread_dv",   bus.data_valid, 1);
        check("t5_reread_data", bus.data_out,   16'h1000);
        tick(); tick();

        // 6) alternating request / idle
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            bus.req      = (k < 6) && (k % 2 == 0);
            bus.req_addr = 16'h0020 + 16'(k);
            expDv = (k == 4 || k == 6 || k == 8);
            check($sformatf("t6_dv_c%0d", k), bus.data_valid, expDv);
            if (expDv) begin
                check($sformatf("t6_data_c%0d", k), bus.data_out, 16'h1000 + 16'((k - 4) / 2));
                pulses++;
            end
            tick();
        end
        bus.req = 1'b0;
        check("t6_pulses", pulses, 3);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
